decode: RTL
===========

# decode

Decode stage of the pipeline, between instruction fetch and `execute`. It accepts 16-bit instruction words from fetch over a valid/ready handshake and buffers them in a small FIFO. It splits each word into opcode and two operand fields and presents them to `execute` from registered outputs. It holds those outputs while `execute` is stalled or busy with a multi-cycle instruction, and inserts NOP bubbles when no instruction is available.

## Interface
Parameters:
- `WORD_WIDTH`, 16: instruction word width; fixed at 16, fields at [15:12], [11:6], [5:0].
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, minimum 2.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_flush`  in  1  synchronous pipeline flush.
- `i_stall`  in  1  global pipeline stall.
- `i_mult_cycle`  in  1  `execute` busy with a multi-cycle instruction.
- `i_instr`  in  WORD_WIDTH  instruction word from fetch.
- `i_valid`  in  1  `i_instr` valid.
- `o_ready`  out  1  decode can accept a word this cycle.
- `o_opcode`  out  4  opcode to `execute`.
- `o_operand1`  out  6  operand 1 to `execute`.
- `o_operand2`  out  6  operand 2 to `execute`.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, for debug.
- `o_illegal`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- Legal opcodes:
  - `'h0` NOP
  - `'hB` multi-cycle
  - `'hD` ADD rx, ry
  - `'hF` LD rx, imm
  - All other opcodes are illegal.
- `o_ready = (count != FIFO_DEPTH)`. It is combinational from the count only, never from `i_valid`.
- Push:
  - A word is pushed when `i_valid && o_ready && !i_flush`.
  - It is written at `wr_ptr`, and `wr_ptr` wraps modulo FIFO_DEPTH.
- Advance condition: `adv = !i_stall && !i_mult_cycle`.
- On `adv` with the FIFO non-empty:
  - Pop the head entry.
  - Load the output registers from the head fields: opcode [15:12], operand1 [11:6], operand2 [5:0].
- On `adv` with the FIFO empty: load the output registers with all zeros (NOP bubble).
- When `adv` is low: the outputs and the FIFO head are held. Pushes still proceed.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This is legal when full, but no push occurs when full because `o_ready` is low.
- Flush has priority over everything:
  - Output registers, count and both pointers clear to 0.
  - A word offered in the flush cycle is dropped, even though `o_ready` may be high.
  - `o_illegal` is not cleared by flush.
- Reset (asynchronous, including mid-operation):
  - Pointers and count are 0.
  - All outputs are 0.
  - `o_ready` is 1.
  - `o_illegal` is 0.
  - FIFO contents are don't-care.

## Timing
- Accept-to-output latency, FIFO empty and no stall: a word accepted at edge N appears on `o_opcode`/`o_operand*` after edge N+1. There is no combinational path from fetch to `execute`.
- Throughput: one instruction per cycle while `adv` is high.
- `o_ready` reflects the count after the previous edge. It goes low in the cycle after the push that makes the FIFO full.
- `i_mult_cycle` and `i_stall` take effect in the same cycle: the edge ending a cycle where either is high does not change the outputs or pop.
- `o_level` updates on every edge at which the count changes.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - A popped word with an illegal opcode is replaced by NOP (all zeros) on the outputs.
  - `o_illegal` is set on that same edge and stays set until reset.
- `DECODE_ILLEGAL_TRAP_EN` undefined:
  - Every opcode passes through unchanged.
  - `o_illegal` is tied to 0.

## Test plan
- Reset, then push `'hF085` (LD r2, 5) with no stall → outputs are 0/0/0 until the edge after the accept, then opcode F, operand1 2, operand2 5. Idle cycles that follow produce opcode 0.
- Push `'hB040`, `'hD085`, `'hF0C1` back-to-back, holding `i_mult_cycle` high for 3 cycles after B appears → B is held on the outputs for 3 cycles, then D and F follow on consecutive cycles. `o_level` peaks at 2.
- With `i_stall` held high, push 5 words into a depth-4 FIFO → `o_ready` drops after the 4th accept and the 5th word is not taken. Release the stall → the 4 words emerge in order and `o_ready` returns high after the first pop.
- Fill 3 entries, pulse `i_flush` while offering a 4th word → next cycle the outputs are 0, `o_level` is 0, and the 4th word never appears.
- With `DECODE_ILLEGAL_TRAP_EN`, push `'h3123` → the outputs show NOP and `o_illegal` is 1 and stays 1 across a flush. Without the macro, the same word outputs opcode 3, operand1 4, operand2 'h23, and `o_illegal` stays 0.
- Assert `i_rst_n` low asynchronously mid-stream with the FIFO holding 2 entries → outputs and `o_level` go to 0 immediately, without waiting for a clock edge, and `o_ready` goes to 1.

Source files
------------

// File: rtl/decode.sv
// decode: buffers 16-bit instruction words from fetch in a small FIFO, splits
// them into opcode/operand fields and presents them to execute from registers.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (illegal opcodes become NOP
// and raise a sticky o_illegal flag).
module decode #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_stall,
    input  logic                          i_mult_cycle,
    input  logic [WORD_WIDTH-1:0]         i_instr,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [3:0]                    o_opcode,
    output logic [5:0]                    o_operand1,
    output logic [5:0]                    o_operand2,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_illegal
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      count;

    logic                  push;
    logic                  pop;
    logic                  adv;
    logic                  empty;
    logic [WORD_WIDTH-1:0] head;
    logic [3:0]            opcode_nxt;
    logic [5:0]            operand1_nxt;
    logic [5:0]            operand2_nxt;
    logic                  head_illegal;

    // Handshake and advance control; o_ready depends on the count only
    always_comb begin
        o_ready = (count != LVL_W'(FIFO_DEPTH));
        adv     = !i_stall && !i_mult_cycle;
        empty   = (count == '0);
        push    = i_valid && o_ready && !i_flush;
        pop     = adv && !empty;
        head    = mem[rd_ptr];
    end

    // Field split of the head entry, with bubble insertion when empty
    always_comb begin
        opcode_nxt   = 4'h0;
        operand1_nxt = 6'h0;
        operand2_nxt = 6'h0;
        head_illegal = !(head[15:12] inside {4'h0, 4'hB, 4'hD, 4'hF});
        if (!empty) begin
            opcode_nxt   = head[15:12];
            operand1_nxt = head[11:6];
            operand2_nxt = head[5:0];
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (head_illegal) begin
                opcode_nxt   = 4'h0;
                operand1_nxt = 6'h0;
                operand2_nxt = 6'h0;
            end
`endif
        end
    end

    // Instruction storage; contents need no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_instr;
        end
    end

    // Pointers and occupancy; flush empties the buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Registered fields to execute: hold while stalled, bubble when empty
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_opcode   <= 4'h0;
            o_operand1 <= 6'h0;
            o_operand2 <= 6'h0;
        end else if (i_flush) begin
            o_opcode   <= 4'h0;
            o_operand1 <= 6'h0;
            o_operand2 <= 6'h0;
        end else if (adv) begin
            o_opcode   <= opcode_nxt;
            o_operand1 <= operand1_nxt;
            o_operand2 <= operand2_nxt;
        end
    end

    assign o_level = count;

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Sticky illegal flag; only reset clears it, flush does not
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal <= 1'b0;
        end else if (!i_flush && pop && head_illegal) begin
            o_illegal <= 1'b1;
        end
    end
`else
    assign o_illegal = 1'b0;
    logic unused_head_illegal;
    assign unused_head_illegal = head_illegal;
`endif

endmodule
